mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive contended cycles m0 may win before m1 is forced.
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports m0_req/m1_req  in  1  master request valid.
REQ-006 SHALL have ports m0_addr/m1_addr  in  AW  byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata  in  32  store data.
REQ-008 SHALL have ports m0_wmask/m1_wmask  in  4  byte write mask; 4'b0000 means read.
REQ-009 SHALL have ports m0_gnt/m1_gnt  out  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports m0_rvalid/m1_rvalid  out  1  read data valid for the owning master.
REQ-011 SHALL have ports m0_rdata/m1_rdata  out  32  read data.
REQ-012 SHALL have ports mem_addr, mem_wdata  out  AW, 32  to the single-port RAM.
REQ-013 SHALL have port mem_wmask  out  4  to the single-port RAM.
REQ-014 SHALL have port mem_rstrb  out  1  to the single-port RAM.
REQ-015 SHALL have port mem_rdata  in  32  registered RAM output, valid the cycle after mem_rstrb.

Function
REQ-016 SHALL grant at most one master per cycle; a transfer occurs when req and gnt are both high.
REQ-017 SHALL drive mem_addr, mem_wdata and mem_wmask from the granted master, and zeros when nothing is granted.
REQ-018 SHALL assert mem_rstrb only for a granted request with wmask==0.
REQ-019 SHALL grant m0 by fixed priority when only m0 requests or both request, except as REQ-021 states.
REQ-020 SHALL grant m1 whenever m1 requests and m0 does not.
REQ-021 SHALL keep a starve counter that increments on each cycle where both request and m0 is granted.
REQ-022 SHALL clear the starve counter on any m1 grant or any cycle without contention.
REQ-023 SHALL grant m1 instead of m0 when the starve counter equals STARVE_LIMIT and both request; the counter then clears.
REQ-024 SHALL saturate the starve counter at STARVE_LIMIT and never wrap.
REQ-025 SHALL register a response tag (valid, master id) on each granted read.
REQ-026 SHALL assert mN_rvalid for exactly one cycle, the cycle after the read grant, to the tagged master only.
REQ-027 SHALL route mem_rdata to mN_rdata when mN_rvalid is high, and drive 0 otherwise.
REQ-028 SHALL support back-to-back reads, including alternating masters, at one transfer per cycle with no bubble.
REQ-029 SHALL leave tag and rvalid unaffected by writes; writes complete at the grant edge with no response.
REQ-030 SHALL require masters to hold req, addr, wdata and wmask stable until gnt; the arbiter does not latch ungranted requests.
REQ-031 SHALL make gnt independent of the other master's wdata, addr and wmask (no combinational loop through the data paths).

Reset
REQ-032 SHALL, while resetn is low, force all gnt, rvalid, mem_rstrb and mem_wmask outputs to 0.
REQ-033 SHALL, while resetn is low, force rdata and mem_addr to 0, and clear the starve counter and response tag.
REQ-034 SHALL drop a read granted in the cycle reset asserts: no rvalid after reset.
REQ-035 SHALL allow the first grant in the first cycle with resetn high.

Structure
REQ-036 SHALL take master id constants (M0=0, M1=1) and the response-tag struct from shared package mem_arb_pkg.
REQ-037 SHALL implement the starve counter and force-grant decision in sub-module arb_starve_ctr, parameterised by STARVE_LIMIT.
REQ-038 SHALL keep total RTL within 120-400 lines.

Verification
REQ-039 SHALL cover: m0 only, read addr 0x10 with RAM word 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid next cycle with 0xDEADBEEF, m1_rvalid 0.
REQ-040 SHALL cover: both request reads continuously, STARVE_LIMIT=4 -> grant order m0,m0,m0,m0,m1, then the pattern repeats.
REQ-041 SHALL cover: m1 write 0x0000_00A5 wmask 4'b0001 to 0x20, then m0 reads 0x20 -> m0 gets byte 0xA5 in bits [7:0]; no rvalid on the write.
REQ-042 SHALL cover: alternating reads m0@0x0, m1@0x4, m0@0x8 on consecutive cycles -> rvalid pulses alternate masters with the correct data and no gaps.
REQ-043 SHALL cover: reset asserted the cycle after an m1 read grant -> m1_rvalid stays 0, starve counter reads 0, and all outputs are 0 during reset.
REQ-044 SHALL cover: m0 requests while m1 is idle for 10 cycles, then m1 requests -> counter never exceeds 0 before contention, and m1 is granted after 4 contended cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: master ids,
// the registered read-response tag and a small wmask helper.
package mem_arb_pkg;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } resp_tag_t;

    function automatic logic is_read(input logic [3:0] wmask);
        return wmask == 4'b0000;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive contended cycles won by m0 and forces an m1 grant
// once that run reaches STARVE_LIMIT.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic m0_req,
    input  logic m1_req,
    output logic force_m1
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          contended;

    assign contended = m0_req & m1_req;
    assign force_m1  = contended && (starve_cnt == LIMIT_C);

    // A forced m1 win or any uncontended cycle ends m0's run; otherwise m0 won
    // a contended cycle, so the run grows until it saturates at the limit.
    always_ff @(posedge clk) begin
        if (!resetn || !contended || force_m1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT_C) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM: fixed m0 priority with
// starvation relief for m1, and a one-deep tag that routes read data back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wmask,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wmask,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    output logic          mem_rstrb,
    input  logic [31:0]   mem_rdata
);

    logic      force_m1;
    resp_tag_t tag_q;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .resetn  (resetn),
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .force_m1(force_m1)
    );

    // Grants look only at the request lines and the starve decision.
    assign m1_gnt = resetn & m1_req & (~m0_req | force_m1);
    assign m0_gnt = resetn & m0_req & ~m1_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wmask = m0_wmask;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wmask = m1_wmask;
        end
    end

    assign mem_rstrb = (m0_gnt | m1_gnt) & is_read(mem_wmask);

    // The id only moves on reads so a write never disturbs the response path.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_q <= '0;
        end else begin
            tag_q.valid <= mem_rstrb;
            if (mem_rstrb) begin
                tag_q.id <= m1_gnt ? M1 : M0;
            end
        end
    end

    assign m0_rvalid = resetn & tag_q.valid & (tag_q.id == M0);
    assign m1_rvalid = resetn & tag_q.valid & (tag_q.id == M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, directed scenarios with literal
// expectations, and randomized traffic checked against a behavioural model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wmask, m1_wmask;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          mem_rstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'hA0A0_0000;
            1:       return 32'hB1B1_1111;
            2:       return 32'hC2C2_2222;
            4:       return 32'hDEAD_BEEF;
            8:       return 32'h1122_3344;
            default: return 32'h9E37_79B9 ^ (32'(i) * 32'h0101_0101);
        endcase
    endfunction

    // Single-port RAM with a registered read port, indexed by word address.
    logic [31:0] ram [0:63];
    logic [31:0] ram_q = 32'h0;
    logic        load_ram;
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_rstrb) ram_q <= ram[mem_addr[7:2]];
    end
    assign mem_rdata = ram_q;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: m0 wins unless it has already won LIMIT contended cycles in a row;
    // each granted read is answered one cycle later from the expected memory image.
    int          streak = 0;
    logic        pend_valid = 1'b0;
    logic        pend_id = 1'b0;
    logic [31:0] pend_data = 32'h0;
    logic [31:0] exp_mem [0:63];

    always @(negedge clk) begin
        logic e0, e1, er;
        logic [AW-1:0] ea;
        logic [31:0] ew;
        logic [3:0] em;
        e0 = 1'b0; e1 = 1'b0; ea = '0; ew = '0; em = '0;
        if (load_ram)
            for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        if (resetn) begin
            e1 = m1_req && (!m0_req || streak == LIMIT);
            e0 = m0_req && !e1;
            if (e0) begin ea = m0_addr; ew = m0_wdata; em = m0_wmask; end
            if (e1) begin ea = m1_addr; ew = m1_wdata; em = m1_wmask; end
        end
        er = (e0 || e1) && em == 4'h0;
        checkOutput("m0_gnt", 32'(m0_gnt), 32'(e0));
        checkOutput("m1_gnt", 32'(m1_gnt), 32'(e1));
        checkOutput("mem_addr", 32'(mem_addr), 32'(ea));
        checkOutput("mem_wdata", mem_wdata, ew);
        checkOutput("mem_wmask", 32'(mem_wmask), 32'(em));
        checkOutput("mem_rstrb", 32'(mem_rstrb), 32'(er));
        checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(resetn && pend_valid && !pend_id));
        checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(resetn && pend_valid && pend_id));
        checkOutput("m0_rdata", m0_rdata, (resetn && pend_valid && !pend_id) ? pend_data : 32'h0);
        checkOutput("m1_rdata", m1_rdata, (resetn && pend_valid && pend_id) ? pend_data : 32'h0);
        if (resetn) checkOutput("starve_cnt", 32'(dut.u_starve.starve_cnt), 32'(streak));
        if (!resetn) begin
            streak     = 0;
            pend_valid = 1'b0;
        end else begin
            streak     = (m0_req && m1_req && e0) ? streak + 1 : 0;
            pend_valid = er;
            pend_id    = e1;
            pend_data  = exp_mem[ea[7:2]];
            for (int b = 0; b < 4; b++)
                if (em[b]) exp_mem[ea[7:2]][8*b +: 8] = ew[8*b +: 8];
        end
    end

    task automatic applyStimulus(input logic rn,
                                 input logic r0, input logic [AW-1:0] a0, input logic [31:0] d0, input logic [3:0] k0,
                                 input logic r1, input logic [AW-1:0] a1, input logic [31:0] d1, input logic [3:0] k1);
        @(posedge clk);
        #1;
        resetn = rn;
        m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_wmask = k0;
        m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_wmask = k1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic rn);
        applyStimulus(rn, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic          n0, n1;
        logic [AW-1:0] na0, na1;
        logic [31:0]   nd0, nd1;
        logic [3:0]    nk0, nk1;
        logic          rn;
        resetn = 1'b0; load_ram = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        idle(1'b0);
        idle(1'b0);
        load_ram = 1'b0;
        idle(1'b0);

        // Single m0 read of 0x10
        applyStimulus(1'b1, 1'b1, 32'h10, '0, 4'h0, 1'b0, '0, '0, '0);
        checkOutput("lit_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("lit_rstrb", 32'(mem_rstrb), 32'd1);
        idle(1'b1);
        checkOutput("lit_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("lit_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        checkOutput("lit_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // Continuous contention: m0 x4, then m1, repeating
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h40, '0, 4'h0, 1'b1, 32'h48, '0, 4'h0);
            checkOutput("lit_starve_m1_gnt", 32'(m1_gnt), 32'(i % 5 == 4));
        end
        idle(1'b1);

        // Byte write by m1 then read-back by m0
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 32'h20, 32'h0000_00A5, 4'b0001);
        checkOutput("lit_wr_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("lit_wr_rstrb", 32'(mem_rstrb), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h20, '0, 4'h0, 1'b0, '0, '0, '0);
        checkOutput("lit_wr_no_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
        idle(1'b1);
        checkOutput("lit_wr_readback", m0_rdata, 32'h1122_33A5);

        // Alternating masters, back to back
        applyStimulus(1'b1, 1'b1, 32'h0, '0, 4'h0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 32'h4, '0, 4'h0);
        checkOutput("lit_alt_m0_data", m0_rdata, 32'hA0A0_0000);
        applyStimulus(1'b1, 1'b1, 32'h8, '0, 4'h0, 1'b0, '0, '0, '0);
        checkOutput("lit_alt_m1_data", m1_rdata, 32'hB1B1_1111);
        checkOutput("lit_alt_m0_quiet", 32'(m0_rvalid), 32'd0);
        idle(1'b1);
        checkOutput("lit_alt_m0_data2", m0_rdata, 32'hC2C2_2222);

        // Reset right after an m1 read grant
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 32'h44, '0, 4'h0);
        checkOutput("lit_rst_m1_gnt", 32'(m1_gnt), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h10, '0, 4'h0, 1'b1, 32'h14, '0, 4'h0);
        checkOutput("lit_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("lit_rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        checkOutput("lit_rst_addr", 32'(mem_addr), 32'd0);
        idle(1'b0);
        applyStimulus(1'b1, 1'b1, 32'h10, '0, 4'h0, 1'b0, '0, '0, '0);
        checkOutput("lit_post_rst_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("lit_post_rst_cnt", 32'(dut.u_starve.starve_cnt), 32'd0);
        idle(1'b1);
        checkOutput("lit_post_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // m0 alone for 10 cycles, then contention
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h30, '0, 4'h0, 1'b0, '0, '0, '0);
            checkOutput("lit_solo_cnt", 32'(dut.u_starve.starve_cnt), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h30, '0, 4'h0, 1'b1, 32'h34, '0, 4'h0);
            checkOutput("lit_contend_m1_gnt", 32'(m1_gnt), 32'(i == 4));
        end

        // Randomized traffic; an ungranted request is held until granted
        for (int c = 0; c < 2000; c++) begin
            rn = ($urandom_range(0, 99) != 0);
            n0 = m0_req; na0 = m0_addr; nd0 = m0_wdata; nk0 = m0_wmask;
            n1 = m1_req; na1 = m1_addr; nd1 = m1_wdata; nk1 = m1_wmask;
            if (!(m0_req && !m0_gnt)) begin
                n0  = ($urandom_range(0, 9) < 6);
                na0 = AW'($urandom_range(0, 255));
                nd0 = $urandom;
                nk0 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if (!(m1_req && !m1_gnt)) begin
                n1  = ($urandom_range(0, 9) < 6);
                na1 = AW'($urandom_range(0, 255));
                nd1 = $urandom;
                nk1 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            applyStimulus(rn, n0, na0, nd0, nk0, n1, na1, nd1, nk1);
        end
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
